// File: rtl/alu_issue_if.sv
// Issue-stage bundle: register-read input slot and ALU operand output channel.
// The out_illegal field exists only when ALU_ISSUE_ILLEGAL_EN is defined.
interface alu_issue_if;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] in_inst;
  logic [31:0] in_pc;
  logic [31:0] in_rs1_val;
  logic [31:0] in_rs2_val;

  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_op1;
  logic [31:0] out_op2;
  logic [3:0]  out_alu_op;
  logic [4:0]  out_rd;
  logic [31:0] out_pc;
  logic        out_is_branch;
  logic [2:0]  out_br_f3;
`ifdef ALU_ISSUE_ILLEGAL_EN
  logic        out_illegal;

  modport master (
    output in_valid, in_inst, in_pc, in_rs1_val, in_rs2_val, out_ready,
    input  in_ready, out_valid, out_op1, out_op2, out_alu_op, out_rd, out_pc,
           out_is_branch, out_br_f3, out_illegal
  );
  modport slave (
    input  in_valid, in_inst, in_pc, in_rs1_val, in_rs2_val, out_ready,
    output in_ready, out_valid, out_op1, out_op2, out_alu_op, out_rd, out_pc,
           out_is_branch, out_br_f3, out_illegal
  );
`else
  modport master (
    output in_valid, in_inst, in_pc, in_rs1_val, in_rs2_val, out_ready,
    input  in_ready, out_valid, out_op1, out_op2, out_alu_op, out_rd, out_pc,
           out_is_branch, out_br_f3
  );
  modport slave (
    input  in_valid, in_inst, in_pc, in_rs1_val, in_rs2_val, out_ready,
    output in_ready, out_valid, out_op1, out_op2, out_alu_op, out_rd, out_pc,
           out_is_branch, out_br_f3
  );
`endif
endinterface

// File: rtl/alu_issue.sv
// RV32I ALU issue stage: decodes into operand bundles held in a 2-entry skid buffer.
// Macro ALU_ISSUE_ILLEGAL_EN: enqueue illegal encodings flagged instead of dropping them.
module alu_issue #(
  parameter int XLEN     = 32,
  parameter int ALU_OP_W = 4
) (
  input  logic        clk_in,
  input  logic        rst_in,
  input  logic        rdy_in,
  input  logic        flush,
  alu_issue_if.slave  bus
);

  typedef enum logic [ALU_OP_W-1:0] {
    ALU_AUIPC = 0, ALU_ADD = 1, ALU_SUB = 2, ALU_AND = 3, ALU_OR  = 4, ALU_XOR = 5,
    ALU_SLL   = 6, ALU_SRL = 7, ALU_SRA = 8, ALU_SLT = 9, ALU_SLTU = 10, ALU_LUI = 11
  } alu_op_e;

  typedef enum logic [6:0] {
    OPC_OP_IMM = 7'b0010011,
    OPC_OP     = 7'b0110011,
    OPC_LUI    = 7'b0110111,
    OPC_AUIPC  = 7'b0010111,
    OPC_BRANCH = 7'b1100011
  } opcode_e;

  typedef struct packed {
    logic [XLEN-1:0]     op1;
    logic [XLEN-1:0]     op2;
    logic [XLEN-1:0]     pc;
    logic [ALU_OP_W-1:0] alu_op;
    logic [4:0]          rd;
    logic                is_branch;
    logic [2:0]          br_f3;
`ifdef ALU_ISSUE_ILLEGAL_EN
    logic                illegal;
`endif
  } entry_t;

  // alt selects the funct7=0100000 variant of the 000 and 101 groups.
  function automatic alu_op_e f3_op(input logic [2:0] f3, input logic alt);
    unique case (f3)
      3'b000:  return alt ? ALU_SUB : ALU_ADD;
      3'b001:  return ALU_SLL;
      3'b010:  return ALU_SLT;
      3'b011:  return ALU_SLTU;
      3'b100:  return ALU_XOR;
      3'b101:  return alt ? ALU_SRA : ALU_SRL;
      3'b110:  return ALU_OR;
      default: return ALU_AND;
    endcase
  endfunction

  logic [6:0] opcode;
  logic [2:0] f3;
  logic [6:0] f7;
  logic       unused_rs1_idx;
  entry_t     dec;
  logic       dec_legal;

  assign opcode         = bus.in_inst[6:0];
  assign f3             = bus.in_inst[14:12];
  assign f7             = bus.in_inst[31:25];
  assign unused_rs1_idx = ^bus.in_inst[19:15];

  // NOTE: every always_comb output gets a default first so no path infers a latch.
  always_comb begin
    dec       = '0;
    dec_legal = 1'b1;
    dec.pc    = bus.in_pc;
    dec.rd    = bus.in_inst[11:7];
    case (opcode)
      OPC_OP_IMM: begin
        dec.op1 = bus.in_rs1_val;
        if (f3 == 3'b001 || f3 == 3'b101) begin
          dec.op2   = {27'b0, bus.in_inst[24:20]};
          dec_legal = (f3 == 3'b001) ? (f7 == 7'b0000000)
                                     : (f7 == 7'b0000000 || f7 == 7'b0100000);
        end else begin
          dec.op2 = {{20{bus.in_inst[31]}}, bus.in_inst[31:20]};
        end
        dec.alu_op = f3_op(f3, (f3 == 3'b101) && f7[5]);
      end
      OPC_OP: begin
        dec.op1    = bus.in_rs1_val;
        dec.op2    = bus.in_rs2_val;
        dec.alu_op = f3_op(f3, f7[5]);
        dec_legal  = (f7 == 7'b0000000) ||
                     (f7 == 7'b0100000 && (f3 == 3'b000 || f3 == 3'b101));
      end
      OPC_LUI: begin
        dec.op1    = {12'b0, bus.in_inst[31:12]};
        dec.alu_op = ALU_LUI;
      end
      OPC_AUIPC: begin
        dec.op1    = {12'b0, bus.in_inst[31:12]};
        dec.op2    = bus.in_pc;
        dec.alu_op = ALU_AUIPC;
      end
      OPC_BRANCH: begin
        dec.op1       = bus.in_rs1_val;
        dec.op2       = bus.in_rs2_val;
        dec.rd        = '0;
        dec.is_branch = 1'b1;
        dec.br_f3     = f3;
        unique case (f3[2:1])
          2'b00:   dec.alu_op = ALU_SUB;
          2'b10:   dec.alu_op = ALU_SLT;
          2'b11:   dec.alu_op = ALU_SLTU;
          default: dec_legal  = 1'b0;
        endcase
      end
      default: dec_legal = 1'b0;
    endcase
`ifdef ALU_ISSUE_ILLEGAL_EN
    if (!dec_legal) begin
      dec.op1       = '0;
      dec.op2       = '0;
      dec.alu_op    = ALU_ADD;
      dec.is_branch = 1'b0;
      dec.br_f3     = '0;
      dec.illegal   = 1'b1;
    end
`endif
  end

  entry_t out_q, out_d, skid_q, skid_d;
  logic   out_valid_q, out_valid_d;
  logic   skid_valid_q, skid_valid_d;
  logic   in_ready_q, in_ready_d;
  logic   accept, drain, push;

  assign accept = bus.in_valid & in_ready_q & rdy_in;
  assign drain  = out_valid_q & bus.out_ready & rdy_in;
`ifdef ALU_ISSUE_ILLEGAL_EN
  assign push   = accept;
`else
  assign push   = accept & dec_legal;
`endif

  // With rdy_in low every _d equals its _q, so the whole buffer freezes.
  always_comb begin
    out_d        = out_q;
    skid_d       = skid_q;
    out_valid_d  = out_valid_q;
    skid_valid_d = skid_valid_q;
    if (rdy_in) begin
      if (flush) begin
        out_valid_d  = 1'b0;
        skid_valid_d = 1'b0;
      end else if (!out_valid_q || drain) begin
        if (skid_valid_q) begin
          out_d        = skid_q;
          out_valid_d  = 1'b1;
          skid_valid_d = 1'b0;
        end else begin
          out_d       = push ? dec : out_q;
          out_valid_d = push;
        end
      end else if (push) begin
        skid_d       = dec;
        skid_valid_d = 1'b1;
      end
    end
    in_ready_d = !skid_valid_d;
  end

  // NOTE: both entries are ordinary flops, so the asynchronous reset zeroes their payload too.
  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) begin
      out_q        <= '0;
      skid_q       <= '0;
      out_valid_q  <= 1'b0;
      skid_valid_q <= 1'b0;
      in_ready_q   <= 1'b1;
    end else begin
      // NOTE: non-blocking assignments so every flop samples pre-edge values.
      out_q        <= out_d;
      skid_q       <= skid_d;
      out_valid_q  <= out_valid_d;
      skid_valid_q <= skid_valid_d;
      in_ready_q   <= in_ready_d;
    end
  end

  assign bus.in_ready      = in_ready_q;
  assign bus.out_valid     = out_valid_q;
  assign bus.out_op1       = out_q.op1;
  assign bus.out_op2       = out_q.op2;
  assign bus.out_alu_op    = out_q.alu_op;
  assign bus.out_rd        = out_q.rd;
  assign bus.out_pc        = out_q.pc;
  assign bus.out_is_branch = out_q.is_branch;
  assign bus.out_br_f3     = out_q.br_f3;
`ifdef ALU_ISSUE_ILLEGAL_EN
  assign bus.out_illegal   = out_q.illegal;
`endif

endmodule

// File: tb/tb_alu_issue.sv
// Self-checking bench for alu_issue: a queue-based reference model checked every cycle,
// plus directed literal scenarios. Honours ALU_ISSUE_ILLEGAL_EN when defined.
module tb_alu_issue;

`ifdef ALU_ISSUE_ILLEGAL_EN
  localparam bit ILL_EN = 1'b1;
`else
  localparam bit ILL_EN = 1'b0;
`endif

  logic clk_in = 1'b0;
  logic rst_in = 1'b0;
  logic rdy_in = 1'b1;
  logic flush  = 1'b0;
  bit   cmp_en = 1'b0;
  int   total  = 0;
  int   bad    = 0;

  alu_issue_if bus ();

  alu_issue #(.XLEN(32), .ALU_OP_W(4)) dut (
    .clk_in (clk_in),
    .rst_in (rst_in),
    .rdy_in (rdy_in),
    .flush  (flush),
    .bus    (bus)
  );

  always #5 clk_in = ~clk_in;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  typedef struct packed {
    logic [31:0] op1;
    logic [31:0] op2;
    logic [31:0] pc;
    logic [3:0]  op;
    logic [4:0]  rd;
    logic        br;
    logic [2:0]  f3;
    logic        ill;
    logic        legal;
  } exp_t;

  // Reference decode written straight from the instruction-set rules.
  function automatic exp_t ref_decode(input logic [31:0] inst, input logic [31:0] pc,
                                      input logic [31:0] a, input logic [31:0] b);
    exp_t       e;
    logic [3:0] f3_map [8];
    logic [6:0] opc;
    logic [2:0] f3;
    logic [6:0] f7;
    f3_map = '{4'd1, 4'd6, 4'd9, 4'd10, 4'd5, 4'd7, 4'd4, 4'd3};
    opc = inst[6:0];
    f3  = inst[14:12];
    f7  = inst[31:25];
    e = '0;
    e.legal = 1'b1;
    e.pc = pc;
    e.rd = inst[11:7];
    if (opc == 7'b0010011) begin
      e.op1 = a;
      e.op  = f3_map[f3];
      if (f3 == 3'd1) begin
        e.op2 = {27'b0, inst[24:20]};
        e.legal = (f7 == 7'h00);
      end else if (f3 == 3'd5) begin
        e.op2 = {27'b0, inst[24:20]};
        e.legal = (f7 == 7'h00) || (f7 == 7'h20);
        if (f7 == 7'h20) e.op = 4'd8;
      end else begin
        e.op2 = {{20{inst[31]}}, inst[31:20]};
      end
    end else if (opc == 7'b0110011) begin
      e.op1 = a;
      e.op2 = b;
      e.op  = f3_map[f3];
      if (f7 == 7'h20) begin
        if (f3 == 3'd0)      e.op = 4'd2;
        else if (f3 == 3'd5) e.op = 4'd8;
        else                 e.legal = 1'b0;
      end else if (f7 != 7'h00) begin
        e.legal = 1'b0;
      end
    end else if (opc == 7'b0110111) begin
      e.op1 = {12'b0, inst[31:12]};
      e.op  = 4'd11;
    end else if (opc == 7'b0010111) begin
      e.op1 = {12'b0, inst[31:12]};
      e.op2 = pc;
      e.op  = 4'd0;
    end else if (opc == 7'b1100011) begin
      e.op1 = a;
      e.op2 = b;
      e.rd  = 5'd0;
      e.br  = 1'b1;
      e.f3  = f3;
      if (f3 < 3'd2)      e.op = 4'd2;
      else if (f3 < 3'd4) e.legal = 1'b0;
      else if (f3 < 3'd6) e.op = 4'd9;
      else                e.op = 4'd10;
    end else begin
      e.legal = 1'b0;
    end
    if (!e.legal) begin
      e.op1 = '0;
      e.op2 = '0;
      e.op  = 4'd1;
      e.br  = 1'b0;
      e.f3  = '0;
      e.ill = 1'b1;
    end
    return e;
  endfunction

  // Model: strict FIFO of at most two bundles; head is what the outputs must show.
  exp_t q[$];

  always @(posedge clk_in or negedge rst_in) begin : model
    exp_t e;
    bit   acc;
    bit   drn;
    if (!rst_in) begin
      q.delete();
    end else if (rdy_in) begin
      if (flush) begin
        q.delete();
      end else begin
        acc = bus.in_valid && (q.size() < 2);
        drn = (q.size() > 0) && bus.out_ready;
        e   = ref_decode(bus.in_inst, bus.in_pc, bus.in_rs1_val, bus.in_rs2_val);
        if (drn) void'(q.pop_front());
        if (acc && (e.legal || ILL_EN)) q.push_back(e);
      end
    end
  end

  always @(negedge clk_in) begin
    if (rst_in && cmp_en) begin
      check("out_valid", 32'(bus.out_valid), 32'(q.size() > 0));
      check("in_ready", 32'(bus.in_ready), 32'(q.size() < 2));
      if (q.size() > 0) begin
        check("out_op1", bus.out_op1, q[0].op1);
        check("out_op2", bus.out_op2, q[0].op2);
        check("out_pc", bus.out_pc, q[0].pc);
        check("out_alu_op", 32'(bus.out_alu_op), 32'(q[0].op));
        check("out_rd", 32'(bus.out_rd), 32'(q[0].rd));
        check("out_is_branch", 32'(bus.out_is_branch), 32'(q[0].br));
        check("out_br_f3", 32'(bus.out_br_f3), 32'(q[0].f3));
`ifdef ALU_ISSUE_ILLEGAL_EN
        check("out_illegal", 32'(bus.out_illegal), 32'(q[0].ill));
`endif
      end
    end
  end

  task automatic drive(input logic v, input logic [31:0] inst, input logic [31:0] pc,
                       input logic [31:0] a, input logic [31:0] b);
    bus.in_valid   = v;
    bus.in_inst    = inst;
    bus.in_pc      = pc;
    bus.in_rs1_val = a;
    bus.in_rs2_val = b;
  endtask

  task automatic tick;
    @(posedge clk_in);
    #1;
  endtask

  task automatic settle;
    @(negedge clk_in);
  endtask

  function automatic logic [31:0] rand_inst();
    logic [31:0] inst;
    inst = $urandom;
    case ($urandom_range(0, 6))
      0, 5:    inst[6:0] = 7'b0010011;
      1, 6:    inst[6:0] = 7'b0110011;
      2:       inst[6:0] = 7'b0110111;
      3:       inst[6:0] = 7'b0010111;
      default: inst[6:0] = 7'b1100011;
    endcase
    if ($urandom_range(0, 7) == 0) inst[6:0] = 7'($urandom);
    case ($urandom_range(0, 3))
      0, 2:    inst[31:25] = 7'h00;
      1:       inst[31:25] = 7'h20;
      default: ;
    endcase
    return inst;
  endfunction

  localparam logic [31:0] ADDI_X5_X1_M1 = 32'hFFF0_8293;
  localparam logic [31:0] AUIPC_X3      = 32'h1234_5197;
  localparam logic [31:0] BLTU_X1_X2    = 32'h0020_E063;
  localparam logic [31:0] SUB_X7_X1_X2  = 32'h4020_83B3;
  localparam logic [31:0] SRAI_X1_X2_3  = 32'h4031_5093;
  localparam logic [31:0] LUI_X4        = 32'hABCD_E237;

  initial begin
    bus.out_ready = 1'b0;
    drive(1'b1, ADDI_X5_X1_M1, 32'h40, 32'd5, 32'd0);
    settle;
    settle;
    check("rst_out_valid", 32'(bus.out_valid), 32'd0);
    check("rst_in_ready", 32'(bus.in_ready), 32'd1);
    check("rst_out_op1", bus.out_op1, 32'd0);
    check("rst_out_op2", bus.out_op2, 32'd0);
    check("rst_out_pc", bus.out_pc, 32'd0);
    check("rst_out_misc", 32'({bus.out_alu_op, bus.out_rd, bus.out_is_branch, bus.out_br_f3}), 32'd0);
    drive(1'b0, 32'd0, 32'd0, 32'd0, 32'd0);
    rst_in = 1'b1;
    cmp_en = 1'b1;
    bus.out_ready = 1'b1;

    // Single-instruction literal checks, each emitted one cycle after accept.
    drive(1'b1, ADDI_X5_X1_M1, 32'h0, 32'd5, 32'd0); tick; drive(1'b0, 0, 0, 0, 0); settle;
    check("addi_valid", 32'(bus.out_valid), 32'd1);
    check("addi_op1", bus.out_op1, 32'd5);
    check("addi_op2", bus.out_op2, 32'hFFFF_FFFF);
    check("addi_alu_op", 32'(bus.out_alu_op), 32'd1);
    check("addi_rd", 32'(bus.out_rd), 32'd5);

    drive(1'b1, AUIPC_X3, 32'h1000, 32'd0, 32'd0); tick; drive(1'b0, 0, 0, 0, 0); settle;
    check("auipc_op1", bus.out_op1, 32'h0001_2345);
    check("auipc_op2", bus.out_op2, 32'h0000_1000);
    check("auipc_alu_op", 32'(bus.out_alu_op), 32'd0);

    drive(1'b1, BLTU_X1_X2, 32'h2000, 32'd1, 32'd2); tick; drive(1'b0, 0, 0, 0, 0); settle;
    check("bltu_alu_op", 32'(bus.out_alu_op), 32'd10);
    check("bltu_is_branch", 32'(bus.out_is_branch), 32'd1);
    check("bltu_br_f3", 32'(bus.out_br_f3), 32'd6);
    check("bltu_rd", 32'(bus.out_rd), 32'd0);

    drive(1'b1, SUB_X7_X1_X2, 32'h2004, 32'd9, 32'd4); tick; drive(1'b0, 0, 0, 0, 0); settle;
    check("sub_alu_op", 32'(bus.out_alu_op), 32'd2);
    drive(1'b1, SRAI_X1_X2_3, 32'h2008, 32'hF000_0000, 32'd0); tick; drive(1'b0, 0, 0, 0, 0); settle;
    check("srai_alu_op", 32'(bus.out_alu_op), 32'd8);
    check("srai_op2", bus.out_op2, 32'd3);
    drive(1'b1, LUI_X4, 32'h200C, 32'd0, 32'd0); tick; drive(1'b0, 0, 0, 0, 0); settle;
    check("lui_op1", bus.out_op1, 32'h000A_BCDE);
    check("lui_alu_op", 32'(bus.out_alu_op), 32'd11);
    tick; settle;

    // Stall: two held, third refused until the skid slot frees.
    bus.out_ready = 1'b0;
    drive(1'b1, ADDI_X5_X1_M1, 32'h100, 32'd1, 32'd0); tick;
    drive(1'b1, ADDI_X5_X1_M1, 32'h104, 32'd2, 32'd0); tick;
    drive(1'b1, ADDI_X5_X1_M1, 32'h108, 32'd3, 32'd0); settle;
    check("stall_in_ready", 32'(bus.in_ready), 32'd0);
    check("stall_head_pc", bus.out_pc, 32'h100);
    tick; settle;
    check("stall_hold_pc", bus.out_pc, 32'h100);
    bus.out_ready = 1'b1;
    tick; settle;
    check("release_pc_b", bus.out_pc, 32'h104);
    check("release_in_ready", 32'(bus.in_ready), 32'd1);
    tick; drive(1'b0, 0, 0, 0, 0); settle;
    check("release_pc_c", bus.out_pc, 32'h108);
    tick; settle;
    check("release_empty", 32'(bus.out_valid), 32'd0);

    // Flush with both entries full and a new input offered.
    bus.out_ready = 1'b0;
    drive(1'b1, ADDI_X5_X1_M1, 32'h200, 32'd1, 32'd0); tick;
    drive(1'b1, ADDI_X5_X1_M1, 32'h204, 32'd2, 32'd0); tick;
    drive(1'b1, ADDI_X5_X1_M1, 32'h208, 32'd3, 32'd0); flush = 1'b1; tick;
    flush = 1'b0; drive(1'b0, 0, 0, 0, 0); settle;
    check("flush_out_valid", 32'(bus.out_valid), 32'd0);
    check("flush_in_ready", 32'(bus.in_ready), 32'd1);
    bus.out_ready = 1'b1;
    tick; settle;
    check("flush_nothing_emitted", 32'(bus.out_valid), 32'd0);

    // Global freeze while stalled with both entries full.
    bus.out_ready = 1'b0;
    drive(1'b1, ADDI_X5_X1_M1, 32'h300, 32'd1, 32'd0); tick;
    drive(1'b1, ADDI_X5_X1_M1, 32'h304, 32'd2, 32'd0); tick;
    rdy_in = 1'b0;
    bus.out_ready = 1'b1;
    drive(1'b1, ADDI_X5_X1_M1, 32'h308, 32'd3, 32'd0);
    for (int i = 0; i < 3; i++) begin
      tick; settle;
      check("freeze_pc", bus.out_pc, 32'h300);
      check("freeze_valid", 32'(bus.out_valid), 32'd1);
      check("freeze_in_ready", 32'(bus.in_ready), 32'd0);
    end
    rdy_in = 1'b1;
    drive(1'b0, 0, 0, 0, 0);
    tick; tick; settle;
    check("freeze_drained", 32'(bus.out_valid), 32'd0);

    // Opcode 0000000 is illegal.
    drive(1'b1, 32'h0000_0280, 32'h400, 32'd7, 32'd8); tick; drive(1'b0, 0, 0, 0, 0); settle;
`ifdef ALU_ISSUE_ILLEGAL_EN
    check("illegal_valid", 32'(bus.out_valid), 32'd1);
    check("illegal_flag", 32'(bus.out_illegal), 32'd1);
    check("illegal_alu_op", 32'(bus.out_alu_op), 32'd1);
    check("illegal_ops", bus.out_op1 | bus.out_op2, 32'd0);
`else
    check("illegal_dropped", 32'(bus.out_valid), 32'd0);
    check("illegal_in_ready", 32'(bus.in_ready), 32'd1);
`endif
    tick; settle;

    // Randomized traffic against the model.
    for (int i = 0; i < 3000; i++) begin
      rdy_in        = ($urandom_range(0, 9) != 0);
      flush         = rdy_in && ($urandom_range(0, 31) == 0);
      bus.out_ready = ($urandom_range(0, 9) < 6);
      drive($urandom_range(0, 9) < 7, rand_inst(), $urandom, $urandom, $urandom);
      tick;
    end

    rdy_in = 1'b1;
    flush = 1'b0;
    bus.out_ready = 1'b1;
    drive(1'b0, 0, 0, 0, 0);
    tick; tick; tick; settle;
    check("final_empty", 32'(bus.out_valid), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/alu_issue.md
ALU_ISSUE -- requirements
Module: alu_issue

Interface
REQ-001 Parameter: XLEN, 32, datapath width; only 32 is supported.
REQ-002 Parameter: ALU_OP_W, 4, width of out_alu_op.
REQ-003 clk_in  input  1  single system clock; all state updates on the rising edge.
REQ-004 rst_in  input  1  asynchronous, active-low reset.
REQ-005 rdy_in  input  1  global ready; when low, the block SHALL freeze all state and perform no transfer.
REQ-006 in_valid  input  1  decoded-instruction slot valid from the register-read stage.
REQ-007 in_ready  output  1  block can accept an input this cycle.
REQ-008 in_inst  input  32  raw RV32I instruction word.
REQ-009 in_pc  input  32  instruction address.
REQ-010 in_rs1_val / in_rs2_val  input  32 each  source operand values.
REQ-011 flush  input  1  discard all held entries (branch mispredict).
REQ-012 out_valid  output  1  ALU operand bundle valid.
REQ-013 out_ready  input  1  downstream execute stage accepts the bundle.
REQ-014 out_op1 / out_op2  output  32 each  ALU operands.
REQ-015 out_alu_op  output  4  ALU opcode: AUIPC=0, ADD=1, SUB=2, AND=3, OR=4, XOR=5, SLL=6, SRL=7, SRA=8, SLT=9, SLTU=10, LUI=11.
REQ-016 out_rd  output  5  destination register (0 for branches).
REQ-017 out_pc  output  32  pc of the bundle.
REQ-018 out_is_branch / out_br_f3  output  1 / 3  conditional-branch flag and funct3.
REQ-019 out_illegal  output  1  entry is an unsupported encoding (present only under REQ-034).

Function
REQ-020 Accept SHALL occur when in_valid & in_ready & rdy_in; drain SHALL occur when out_valid & out_ready & rdy_in.
REQ-021 Storage SHALL consist of a 2-entry skid buffer: output register plus one skid register; order is strict FIFO.
REQ-022 Latency from accept to out_valid SHALL be 1 cycle when the output register is empty or drains in the same cycle.
REQ-023 in_ready SHALL be registered and equal to NOT(skid register valid); an accept while the output register is stalled SHALL fill the skid register.
REQ-024 Drain with skid full SHALL move the skid entry to the output register and raise in_ready the next cycle; accept and drain in the same cycle SHALL both take effect.
REQ-025 Output fields SHALL hold stable while out_valid=1 and out_ready=0.
REQ-026 flush SHALL clear both entries at the next edge, overriding a simultaneous accept (input dropped), and set in_ready=1.
REQ-027 OP-IMM (0010011): op1=rs1; op2=sign-extended imm[31:20]; ADDI/SLTI/SLTIU/XORI/ORI/ANDI map to 1/9/10/5/4/3.
REQ-028 Shifts: op2={27'b0, shamt}; SLLI/SLLI-R=6, SRLI/SRL=7, SRAI/SRA=8 (funct7=0100000).
REQ-029 OP (0110011): op1=rs1, op2=rs2; funct7=0100000 with funct3 000 selects SUB, else funct3 maps as REQ-027/028.
REQ-030 LUI: op1={12'b0, inst[31:12]}, op2=0, alu_op=11; AUIPC: op1={12'b0, inst[31:12]}, op2=pc, alu_op=0.
REQ-031 BRANCH (1100011): op1=rs1, op2=rs2, out_rd=0, is_branch=1; BEQ/BNE -> SUB, BLT/BGE -> SLT, BLTU/BGEU -> SLTU.
REQ-032 Illegal: any other opcode, funct7 not in {0000000, 0100000}, 0100000 with funct3 not in {000, 101}, SLLI with funct7!=0, branch funct3 010/011.

Reset
REQ-033 While rst_in=0: out_valid=0, in_ready=1, every other output and both entries zero; state frozen until rst_in rises, mid-transfer data discarded.

Configuration
REQ-034 Macro ALU_ISSUE_ILLEGAL_EN: defined -> illegal inputs are enqueued with out_illegal=1, out_alu_op=ADD, operands zero; undefined -> illegal inputs are accepted and silently dropped, out_illegal port absent.

Verification
REQ-035 ADDI x5,x1,-1 (rs1=5), out_ready=1 -> next cycle out_valid=1, op1=5, op2=0xFFFFFFFF, alu_op=1, rd=5.
REQ-036 AUIPC x3,0x12345 at pc=0x1000 -> op1=0x00012345, op2=0x1000, alu_op=0.
REQ-037 out_ready=0, three back-to-back inputs -> two held, in_ready=0 after second; release -> emitted in order, third then accepted.
REQ-038 BLTU rs1=1, rs2=2 -> alu_op=10, is_branch=1, br_f3=110, rd=0.
REQ-039 flush with in_valid=1 and both entries full -> next cycle out_valid=0, in_ready=1, no entry emitted.
REQ-040 rdy_in=0 for 3 cycles mid-stall -> outputs unchanged; with macro, opcode 0000000 -> out_illegal=1.
